// File: rtl/mesi_snoop_ctrl.sv
// MESI snooping coherence controller for one direct-mapped cache: per-line state/tag
// store, a single-request miss sequencer and a bus snooper that runs every cycle.
module mesi_snoop_ctrl #(
  parameter int IDX_W = 2,
  parameter int TAG_W = 6,
  localparam int AW    = TAG_W + IDX_W,
  localparam int LINES = 32'd1 << IDX_W
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             cpu_valid,
  input  logic             cpu_write,
  input  logic [AW-1:0]    cpu_addr,
  output logic             cpu_ready,
  output logic             cpu_done,
  output logic             cpu_hit,
  input  logic [1:0]       snoop_cmd,
  input  logic [AW-1:0]    snoop_addr,
  input  logic             shared_in,
  output logic [1:0]       bus_out,
  output logic [AW-1:0]    bus_addr,
  output logic [1:0]       mem_out,
  output logic [AW-1:0]    mem_addr,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {SEQ_IDLE = 2'b00, SEQ_WB = 2'b01, SEQ_MISS = 2'b10, SEQ_FILL = 2'b11} seq_e;

  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;
  localparam logic [1:0] CMD_NONE = 2'b00, CMD_RD = 2'b01, CMD_WR = 2'b10, CMD_INV = 2'b11;
  localparam logic [1:0] MEM_NONE = 2'b00, MEM_FLUSH = 2'b01, MEM_WB = 2'b10;

  logic [1:0]       state_q [LINES];
  logic [1:0]       state_d [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];
  logic [TAG_W-1:0] tag_d   [LINES];
  seq_e             seq_q, seq_d;
  logic [AW-1:0]    req_addr_q, req_addr_d;
  logic             req_write_q, req_write_d;
  logic             cpu_done_q, cpu_done_d, cpu_hit_q, cpu_hit_d;
  logic [1:0]       bus_out_q, bus_out_d, mem_out_q, mem_out_d;
  logic [AW-1:0]    bus_addr_q, bus_addr_d, mem_addr_q, mem_addr_d;

  logic [IDX_W-1:0] snp_idx, cur_idx;
  logic [TAG_W-1:0] snp_tag, cur_tag;
  logic [AW-1:0]    cur_addr;
  logic             cur_write, snp_flush, line_hit, victim_m, wb_req, bus_req;

  // Next-state: snoop first, then the CPU side sees the post-snoop line state.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    seq_d       = seq_q;
    req_addr_d  = req_addr_q;
    req_write_d = req_write_q;
    cpu_done_d  = 1'b0;
    cpu_hit_d   = 1'b0;
    bus_out_d   = CMD_NONE;
    bus_addr_d  = bus_addr_q;
    mem_out_d   = MEM_NONE;
    mem_addr_d  = mem_addr_q;
    wb_req      = 1'b0;
    bus_req     = 1'b0;

    snp_idx = snoop_addr[IDX_W-1:0];
    snp_tag = snoop_addr[AW-1:IDX_W];
    if ((snoop_cmd != CMD_NONE) && (tag_q[snp_idx] == snp_tag) && (state_q[snp_idx] != ST_I)) begin
      snp_flush        = (state_q[snp_idx] == ST_M) && (snoop_cmd != CMD_INV);
      state_d[snp_idx] = (snoop_cmd == CMD_RD) ? ST_S : ST_I;
    end else begin
      snp_flush = 1'b0;
    end
    if (snp_flush) begin
      mem_out_d  = MEM_FLUSH;
      mem_addr_d = snoop_addr;
    end else begin
      mem_out_d = MEM_NONE;
    end

    cur_addr  = (seq_q == SEQ_IDLE) ? cpu_addr : req_addr_q;
    cur_write = (seq_q == SEQ_IDLE) ? cpu_write : req_write_q;
    cur_idx   = cur_addr[IDX_W-1:0];
    cur_tag   = cur_addr[AW-1:IDX_W];
    line_hit  = (tag_q[cur_idx] == cur_tag) && (state_d[cur_idx] != ST_I);
    victim_m  = (state_d[cur_idx] == ST_M);

    case (seq_q)
      SEQ_IDLE: begin
        if (cpu_valid) begin
          req_addr_d  = cpu_addr;
          req_write_d = cpu_write;
          if (line_hit) begin
            cpu_done_d = 1'b1;
            cpu_hit_d  = 1'b1;
            if (cpu_write && (state_d[cur_idx] == ST_S)) begin
              bus_out_d  = CMD_INV;
              bus_addr_d = cpu_addr;
            end else begin
              bus_out_d = CMD_NONE;
            end
            state_d[cur_idx] = cpu_write ? ST_M : state_d[cur_idx];
          end else if (victim_m) begin
            seq_d  = SEQ_WB;
            wb_req = 1'b1;
          end else begin
            seq_d   = SEQ_MISS;
            bus_req = 1'b1;
          end
        end else begin
          seq_d = SEQ_IDLE;
        end
      end
      // Victim still dirty means the write-back lost mem_out to a flush: retry it.
      SEQ_WB: begin
        if (victim_m) begin
          wb_req = 1'b1;
        end else begin
          seq_d   = SEQ_MISS;
          bus_req = 1'b1;
        end
      end
      SEQ_MISS: begin
        tag_d[cur_idx]   = cur_tag;
        state_d[cur_idx] = cur_write ? ST_M : (shared_in ? ST_S : ST_E);
        cpu_done_d       = 1'b1;
        seq_d            = SEQ_FILL;
      end
      SEQ_FILL: seq_d = SEQ_IDLE;
      default:  seq_d = SEQ_IDLE;
    endcase

    if (wb_req && !snp_flush) begin
      mem_out_d        = MEM_WB;
      mem_addr_d       = {tag_q[cur_idx], cur_idx};
      state_d[cur_idx] = ST_I;
    end else begin
      mem_addr_d = mem_addr_d;
    end
    if (bus_req) begin
      bus_out_d  = cur_write ? CMD_WR : CMD_RD;
      bus_addr_d = cur_addr;
    end else begin
      bus_addr_d = bus_addr_d;
    end
  end

  // State store, sequencer and registered outputs.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LINES; i++) begin
        state_q[i] <= ST_I;
        tag_q[i]   <= '0;
      end
      seq_q       <= SEQ_IDLE;
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_hit_q   <= 1'b0;
      bus_out_q   <= CMD_NONE;
      bus_addr_q  <= '0;
      mem_out_q   <= MEM_NONE;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      seq_q       <= seq_d;
      req_addr_q  <= req_addr_d;
      req_write_q <= req_write_d;
      cpu_done_q  <= cpu_done_d;
      cpu_hit_q   <= cpu_hit_d;
      bus_out_q   <= bus_out_d;
      bus_addr_q  <= bus_addr_d;
      mem_out_q   <= mem_out_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign cpu_ready = (seq_q == SEQ_IDLE);
  assign cpu_done  = cpu_done_q;
  assign cpu_hit   = cpu_hit_q;
  assign bus_out   = bus_out_q;
  assign bus_addr  = bus_addr_q;
  assign mem_out   = mem_out_q;
  assign mem_addr  = mem_addr_q;
  assign dbg_state = state_q[dbg_idx];

endmodule

// File: doc/mesi_snoop_ctrl.md
Name: mesi_snoop_ctrl

Overview:
- Snooping MESI coherence controller for a direct-mapped cache of 2**IDX_W lines. Holds per-line MESI state and tag internally.
- Serves one CPU request at a time through a valid/ready handshake with a miss sequencer (write-back, bus miss, fill).
- Snoops the shared bus every cycle, independent of the sequencer.
- Sits between the CPU port, the snooping bus and the memory write-back path of one cache in the multiprocessor model.

Parameters:
IDX_W, 2, index width; LINES = 2**IDX_W
TAG_W, 6, tag width; address width AW = TAG_W+IDX_W

Ports:
clock  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
cpu_valid  in  1  CPU request present
cpu_write  in  1  1=write, 0=read
cpu_addr  in  AW  {tag,index}
cpu_ready  out  1  controller can accept a request
cpu_done  out  1  one-cycle pulse, request complete
cpu_hit  out  1  valid with cpu_done: 1=hit, 0=miss
snoop_cmd  in  2  00 none, 01 read miss, 10 write miss, 11 invalidate
snoop_addr  in  AW  snooped address
shared_in  in  1  another cache holds the line; sampled in FILL
bus_out  out  2  same encoding as snoop_cmd
bus_addr  out  AW  address for bus_out
mem_out  out  2  00 none, 01 flush (snoop write-back, abort mem access), 10 eviction write-back
mem_addr  out  AW  address for mem_out
dbg_idx  in  IDX_W  debug line select
dbg_state  out  2  combinational state of line dbg_idx

Behaviour:
- State encoding: I=00, S=01, E=10, M=11.
- Reset: all lines I, tags 0, sequencer IDLE.
- Registered outputs reset to 0: bus_out, mem_out, cpu_done, cpu_hit, addresses.
- Reset mid-miss aborts the miss with no completion pulse.
- Handshake: cpu_ready=1 only in IDLE. A request is accepted on a rising edge with cpu_valid&cpu_ready. Address and write bit are latched on acceptance.
- bus_out and mem_out are registered, one-cycle pulses. The value is 00 in every cycle not listed below.
- Hit (tag match, state != I), completes in 1 cycle: cpu_done=1 and cpu_hit=1 on the cycle after acceptance.
  - Read: state unchanged.
  - Write in E or M: state -> M, no bus traffic.
  - Write in S: bus_out=11, bus_addr=addr, state -> M.
- Miss sequencer states: IDLE -> [WB] -> MISS -> FILL -> IDLE.
  - WB (entered only when the victim is M): mem_out=10, mem_addr={victim tag, idx}; victim -> I.
  - MISS: bus_out=01 for a read, 10 for a write.
  - FILL: install the tag and sample shared_in. Write -> M. Read -> S if shared_in, else E. cpu_done=1, cpu_hit=0.
  - Latency from acceptance to cpu_done: 3 cycles with WB, 2 without.
  - A victim in S or E is dropped silently.
- Snoop: evaluated every cycle, in every sequencer state, on the line whose tag matches and whose state != I.
  - Read miss: S->S; E->S; M->S with mem_out=01.
  - Write miss: S,E->I; M->I with mem_out=01.
  - Invalidate: S,E,M->I, no flush.
  - No match: no action.
- Simultaneous events:
  - Snoop and accepted CPU request on the same line in the same cycle: the CPU request is evaluated against the post-snoop state. Example: write with E + snoop invalidate -> miss path.
  - Snoop flush and WB in the same cycle: the snoop flush owns mem_out. The sequencer stays in WB and retries next cycle.
  - A snoop that hits the victim during WB: the victim is already I after the flush, so WB is skipped and the sequencer goes to MISS.
  - Snoop on the index being filled, old tag, during MISS: applied to the old contents.
  - Snoop on the new tag before FILL completes: ignored.

Test Plan:
- Reset, then read addr 0x05 with shared_in=0 -> bus_out=01 next cycle; cpu_done with cpu_hit=0 two cycles after acceptance; dbg_state(idx1)=10.
- Repeat read 0x05 -> cpu_done=1, cpu_hit=1 after 1 cycle, no bus traffic. Write 0x05 -> state 11, bus_out=00.
- Line 1 in M, tag 1; read 0x09 (same index, tag 2) -> mem_out=10 with mem_addr=0x05, then bus_out=01 with bus_addr=0x09; cpu_done 3 cycles after acceptance.
- Line in M; snoop_cmd=01 same addr -> mem_out=01, state 01. Then snoop_cmd=11 -> state 00, mem_out=00.
- Read miss with shared_in=1 -> S. Write 0x05 -> bus_out=11, state 11.
- Same cycle: accept write to an E line plus snoop invalidate of that line -> miss path, bus_out=10, final state 11. Assert Reset during MISS -> all outputs 0, all lines I, cpu_ready=1 after release.
